// File: rtl/rtc_pkg.sv
// rtc_pkg: field widths, terminal values and the packed time record shared by the RTC block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rtc_pkg;

   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;
   localparam int HR_W    = 5;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;

   // Hours in the top bits so the record reads hh:mm:ss when dumped as one vector
   typedef struct packed {
      logic [HR_W-1:0]  hours;
      logic [MIN_W-1:0] minutes;
      logic [SEC_W-1:0] seconds;
   } rtc_time_t;

endpackage

// File: rtl/top_clk_v4_rtc_if.sv
// top_clk_v4_rtc_if: time-of-day bus from the RTC to display/decoder logic.
// Latency: n/a (wires only); every field is driven straight from a register.
// Backpressure: none; consumers sample the fields whenever they like.
interface top_clk_v4_rtc_if;
   import rtc_pkg::*;

   logic [SEC_W-1:0] seconds_out;
   logic [MIN_W-1:0] minutes_out;
   logic [HR_W-1:0]  hours_out;

   // The RTC drives the time fields
   modport master (
      output seconds_out,
      output minutes_out,
      output hours_out
   );

   // Display/decoder side only observes them
   modport slave (
      input seconds_out,
      input minutes_out,
      input hours_out
   );

endinterface

// File: rtl/rtc_mod_counter.sv
// rtc_mod_counter: modulo-(MAX+1) up counter with a carry-out for ripple chaining of time fields.
// Latency: value steps on the edge where inc is sampled high; carry is combinational from inc.
// Backpressure: none; inc is a one-cycle enable that is always accepted.
module rtc_mod_counter #(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         carry
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q;
   logic         at_max;

   // A >= test lets an out-of-range value (only reachable by forcing) recover on its next step
   assign at_max = (cnt_q >= MAX_V);
   assign carry  = inc && at_max;
   assign value  = cnt_q;

   // Advance on inc, wrapping to zero at the terminal value; hold otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (inc) begin
         if (at_max) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + W'(1);
         end
      end
   end

endmodule

// File: rtl/top_clk_v4_rtc.sv
// top_clk_v4_rtc: 24-hour binary real-time clock (hh:mm:ss) advanced by a prescaled 1 Hz tick.
// Latency: fields update one cycle after the prescaler terminal count; a full rollover lands on one edge.
// Backpressure: none; outputs are free-running registers. Build option: SIM_FAST_TICK_EN (tick every SIM_TICK_DIV cycles).
module top_clk_v4_rtc
   import rtc_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned SIM_TICK_DIV = 10
) (
   input  logic               clk,
   input  logic               reset,
   top_clk_v4_rtc_if.master   time_if
);

`ifdef SIM_FAST_TICK_EN
   // Shortened tick period so whole minutes/hours pass in a handful of cycles
   localparam bit FAST_TICK = 1'b1;
`else
   // True 1 Hz tick from the system clock
   localparam bit FAST_TICK = 1'b0;
`endif

   localparam int unsigned DIV    = FAST_TICK ? SIM_TICK_DIV : CLK_FREQ_HZ;
   localparam int          PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre_cnt_q;
   logic             tick;
   logic             tick_q;

   logic             sec_carry;
   logic             min_carry;
   // The day rollover carry out of the hours field has no consumer
   logic             unused_day_carry;

   rtc_time_t        cur_time;

   assign tick = (pre_cnt_q == PRE_TC);

   // Prescaler: count 0..DIV-1 and wrap, producing one tick cycle per period
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt_q <= '0;
      end else if (tick) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_q + PRE_W'(1);
      end
   end

   // Register the tick so the counter chain sees a clean, glitch-free enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick;
      end
   end

   // Seconds -> minutes -> hours ripple of enables; all three settle within the same cycle
   rtc_mod_counter #(
      .W   (SEC_W),
      .MAX (SEC_MAX)
   ) u_sec (
      .clk   (clk),
      .reset (reset),
      .inc   (tick_q),
      .value (cur_time.seconds),
      .carry (sec_carry)
   );

   rtc_mod_counter #(
      .W   (MIN_W),
      .MAX (MIN_MAX)
   ) u_min (
      .clk   (clk),
      .reset (reset),
      .inc   (sec_carry),
      .value (cur_time.minutes),
      .carry (min_carry)
   );

   rtc_mod_counter #(
      .W   (HR_W),
      .MAX (HR_MAX)
   ) u_hr (
      .clk   (clk),
      .reset (reset),
      .inc   (min_carry),
      .value (cur_time.hours),
      .carry (unused_day_carry)
   );

   assign time_if.seconds_out = cur_time.seconds;
   assign time_if.minutes_out = cur_time.minutes;
   assign time_if.hours_out   = cur_time.hours;

endmodule

// File: tb/tb_top_clk_v4_rtc.sv
// tb_top_clk_v4_rtc: scoreboard bench for the RTC with a 10-cycle tick period.
// Latency: expected hh:mm:ss is queued at the edge a tick lands and compared at the following negedge.
// Backpressure: n/a.
module tb_top_clk_v4_rtc;
   import rtc_pkg::*;

   localparam int unsigned DIV = 10;
   localparam int unsigned DAY = 86400;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   top_clk_v4_rtc_if rtc_if ();

   // Both divider parameters set alike so the tick period is 10 with or without the fast-tick build
   top_clk_v4_rtc #(
      .CLK_FREQ_HZ  (DIV),
      .SIM_TICK_DIV (DIV)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .time_if (rtc_if)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int unsigned n_edge;
   int unsigned tick_cnt;
   int unsigned base;
   int unsigned first_edge;
   logic [31:0] last_exp;
   logic [31:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Time of day in seconds -> decimal hhmmss
   function automatic logic [31:0] hms(input int unsigned t);
      return 32'((t / 3600) * 10000 + ((t / 60) % 60) * 100 + (t % 60));
   endfunction

   function automatic logic [31:0] dut_hms();
      return 32'(rtc_if.hours_out) * 32'd10000 + 32'(rtc_if.minutes_out) * 32'd100
             + 32'(rtc_if.seconds_out);
   endfunction

   task automatic restart_model();
      n_edge     = 0;
      tick_cnt   = 0;
      base       = 0;
      first_edge = 0;
      last_exp   = 32'd0;
      sb_q.delete();
   endtask

   // One clock: model the edge, then sample the DUT at the following negedge
   task automatic step();
      logic [31:0] obs;
      logic        in_range;
      @(posedge clk);
      if (!reset) begin
         n_edge++;
         if (n_edge > 1 && ((n_edge - 1) % DIV) == 0) begin
            tick_cnt++;
            sb_q.push_back(hms((base + tick_cnt) % DAY));
         end
      end
      @(negedge clk);
      obs = dut_hms();
      if (reset) begin
         last_exp = 32'd0;
         chk("rst_zero", obs, 32'd0);
      end else if (sb_q.size() > 0) begin
         last_exp = sb_q.pop_front();
         chk("tick_val", obs, last_exp);
      end else begin
         chk("hold", obs, last_exp);
      end
      in_range = (rtc_if.seconds_out <= 6'd59) && (rtc_if.minutes_out <= 6'd59)
                 && (rtc_if.hours_out <= 5'd23);
      chk("range", {31'd0, in_range}, 32'd1);
      if (!reset && first_edge == 0 && rtc_if.seconds_out != '0) first_edge = n_edge;
   endtask

   task automatic run_ticks(input int unsigned target);
      while (tick_cnt < target) step();
   endtask

   initial begin
      restart_model();
      // Reset held for 100 ns: outputs stay zero on every sample
      for (int i = 0; i < 10; i++) step();
      reset = 1'b0;
      restart_model();

      // First increment lands DIV+1 edges after release
      run_ticks(1);
      chk("first_tick_edge", first_edge, DIV + 1);
      chk("first_sec", 32'(rtc_if.seconds_out), 32'd1);

      run_ticks(59);
      chk("sec_59", 32'(rtc_if.seconds_out), 32'd59);
      chk("min_0_at59", 32'(rtc_if.minutes_out), 32'd0);
      run_ticks(60);
      chk("sec_wrap", 32'(rtc_if.seconds_out), 32'd0);
      chk("min_carry", 32'(rtc_if.minutes_out), 32'd1);

      // Asynchronous reset mid-cycle at 00:01:30
      run_ticks(90);
      chk("pre_rst_time", dut_hms(), 32'd130);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("async_clr", dut_hms(), 32'd0);
      for (int i = 0; i < 3; i++) step();
      reset = 1'b0;
      restart_model();
      run_ticks(1);
      chk("restart_edge", first_edge, DIV + 1);

      // One hour of ticks from a fresh start
      run_ticks(3600);
      chk("hr_1", 32'(rtc_if.hours_out), 32'd1);
      chk("hr_1_min", 32'(rtc_if.minutes_out), 32'd0);
      chk("hr_1_sec", 32'(rtc_if.seconds_out), 32'd0);

      // Jump to 23:59:59 between ticks, then expect a single-edge day rollover
      force dut.u_sec.cnt_q = 6'd59;
      force dut.u_min.cnt_q = 6'd59;
      force dut.u_hr.cnt_q  = 5'd23;
      #1;
      release dut.u_sec.cnt_q;
      release dut.u_min.cnt_q;
      release dut.u_hr.cnt_q;
      base     = (DAY - 1 + DAY - (tick_cnt % DAY)) % DAY;
      last_exp = hms(DAY - 1);
      #1;
      chk("preset_235959", dut_hms(), 32'd235959);
      run_ticks(3601);
      chk("day_wrap_h", 32'(rtc_if.hours_out), 32'd0);
      chk("day_wrap_m", 32'(rtc_if.minutes_out), 32'd0);
      chk("day_wrap_s", 32'(rtc_if.seconds_out), 32'd0);
      run_ticks(3603);
      chk("after_wrap", dut_hms(), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Bound on the whole run
   initial begin
      #2_000_000;
      total++;
      bad++;
      $display("FAIL watchdog: run still active at t=%0t, limit 2000000", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
